// File: rtl/mem_wb_buffer_if.sv
// MEM->WB result channel: push side from the MEM stage, pop side to the register file,
// plus the flush control and the hazard query lines.
interface mem_wb_buffer_if #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              WB_en_in;
   logic              MEM_r_en_in;
   logic [DEST_W-1:0] dest_in;
   logic [DATA_W-1:0] alu_res_in;
   logic [DATA_W-1:0] data_mem_in;
   logic              out_valid;
   logic              out_ready;
   logic              WB_en_out;
   logic [DEST_W-1:0] dest_out;
   logic [DATA_W-1:0] WB_value;
   logic [DEST_W-1:0] src1;
   logic [DEST_W-1:0] src2;
   logic              hazard;

   modport master (
      output flush, in_valid, WB_en_in, MEM_r_en_in, dest_in, alu_res_in, data_mem_in,
      output out_ready, src1, src2,
      input  in_ready, out_valid, WB_en_out, dest_out, WB_value, hazard
   );

   modport slave (
      input  flush, in_valid, WB_en_in, MEM_r_en_in, dest_in, alu_res_in, data_mem_in,
      input  out_ready, src1, src2,
      output in_ready, out_valid, WB_en_out, dest_out, WB_value, hazard
   );
endinterface

// File: rtl/mem_wb_buffer.sv
// Two-entry FIFO between MEM and WB; value mux is resolved at capture so only
// {dest, value} is stored. Also answers RAW hazard queries against buffered entries.
module mem_wb_buffer #(
   parameter int DATA_W = 32,
   parameter int DEST_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   mem_wb_buffer_if.slave  bus
);
   logic [1:0]        count;
   logic              rd_ptr;
   logic              wr_ptr;
   logic [DEST_W-1:0] dest_q [2];
   logic [DATA_W-1:0] val_q  [2];
   logic              push;
   logic              pop;
   logic              slot0_v;
   logic              slot1_v;

   assign bus.in_ready  = (count != 2'd2);
   assign bus.out_valid = (count != 2'd0);
   assign bus.WB_en_out = bus.out_valid;
   assign bus.dest_out  = bus.out_valid ? dest_q[rd_ptr] : '0;
   assign bus.WB_value  = bus.out_valid ? val_q[rd_ptr]  : '0;

   // Non-writing results are accepted as bubbles and never occupy a slot.
   assign push = bus.in_valid & bus.in_ready & bus.WB_en_in & ~bus.flush;
   assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= 2'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         dest_q[0] <= '0;
         dest_q[1] <= '0;
         val_q[0]  <= '0;
         val_q[1]  <= '0;
      end else if (bus.flush) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            dest_q[wr_ptr] <= bus.dest_in;
            val_q[wr_ptr]  <= bus.MEM_r_en_in ? bus.data_mem_in : bus.alu_res_in;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // A slot is live when the FIFO is full, or when it is the sole entry at the head.
   assign slot0_v = (count == 2'd2) | ((count == 2'd1) & ~rd_ptr);
   assign slot1_v = (count == 2'd2) | ((count == 2'd1) &  rd_ptr);

   assign bus.hazard =
      (slot0_v & ((dest_q[0] == bus.src1) | (dest_q[0] == bus.src2))) |
      (slot1_v & ((dest_q[1] == bus.src1) | (dest_q[1] == bus.src2)));
endmodule

// File: tb/tb_mem_wb_buffer.sv
// Directed bench for mem_wb_buffer: a queue model checked every negedge, plus literal pins.
module tb_mem_wb_buffer;
   localparam int DATA_W = 32;
   localparam int DEST_W = 4;

   typedef struct packed {
      logic [DEST_W-1:0] dest;
      logic [DATA_W-1:0] val;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   ent_t mq[$];

   mem_wb_buffer_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) bus ();

   mem_wb_buffer #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO of depth 2 holding only results that write the register file.
   always @(posedge clk) begin
      if (rst) begin
         if (bus.flush) begin
            mq.delete();
         end else begin
            automatic bit   do_pop  = (mq.size() != 0) && bus.out_ready;
            automatic bit   do_push = bus.in_valid && (mq.size() < 2) && bus.WB_en_in;
            automatic ent_t e;
            e.dest = bus.dest_in;
            e.val  = bus.MEM_r_en_in ? bus.data_mem_in : bus.alu_res_in;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
         end
      end
   end

   always @(negedge rst) mq.delete();

   always @(negedge clk) begin
      automatic logic              e_valid = (mq.size() != 0);
      automatic logic [DEST_W-1:0] e_dest  = e_valid ? mq[0].dest : '0;
      automatic logic [DATA_W-1:0] e_val   = e_valid ? mq[0].val  : '0;
      automatic logic              e_haz   = 1'b0;
      foreach (mq[i])
         if (mq[i].dest == bus.src1 || mq[i].dest == bus.src2) e_haz = 1'b1;
      chk("m_out_valid", bus.out_valid, e_valid);
      chk("m_wb_en_out", bus.WB_en_out, e_valid);
      chk("m_dest_out",  bus.dest_out,  e_dest);
      chk("m_wb_value",  bus.WB_value,  e_val);
      chk("m_in_ready",  bus.in_ready,  mq.size() < 2);
      chk("m_hazard",    bus.hazard,    e_haz);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic wb, input logic ld,
                        input logic [DEST_W-1:0] d, input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] mem);
      bus.in_valid    = v;
      bus.WB_en_in    = wb;
      bus.MEM_r_en_in = ld;
      bus.dest_in     = d;
      bus.alu_res_in  = alu;
      bus.data_mem_in = mem;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      bus.src1 = 4'd0;
      bus.src2 = 4'd0;
      idle_in();

      // reset state
      step();
      step();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_in_ready",  bus.in_ready,  1'b1);
      chk("rst_wb_value",  bus.WB_value,  32'd0);
      rst = 1'b1;
      bus.src1 = 4'd15;
      bus.src2 = 4'd15;
      step();

      // single load selects memory data
      bus.out_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 4'd3, 32'h100, 32'hDEAD);
      step();
      idle_in();
      chk("ld_wb_en",  bus.WB_en_out, 1'b1);
      chk("ld_dest",   bus.dest_out,  4'd3);
      chk("ld_value",  bus.WB_value,  32'hDEAD);
      step();
      chk("ld_drained", bus.out_valid, 1'b0);

      // backpressure: fill, stall third, release
      bus.out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 4'd1, 32'd5, 32'hBAD);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd2, 32'd7, 32'hBAD);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd10, 32'd11, 32'hBAD);
      chk("bp_full_ready", bus.in_ready, 1'b0);
      step();
      chk("bp_head1_dest", bus.dest_out, 4'd1);
      chk("bp_head1_val",  bus.WB_value, 32'd5);
      chk("bp_still_full", bus.in_ready, 1'b0);
      bus.out_ready = 1'b1;
      step();
      chk("bp_head2_dest", bus.dest_out, 4'd2);
      chk("bp_head2_val",  bus.WB_value, 32'd7);
      chk("bp_ready_up",   bus.in_ready, 1'b1);
      step();
      idle_in();
      chk("bp_head3_dest", bus.dest_out, 4'd10);
      chk("bp_head3_val",  bus.WB_value, 32'd11);
      step();
      chk("bp_empty", bus.out_valid, 1'b0);

      // simultaneous push/pop with one entry
      bus.out_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h44, 32'h0);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd6, 32'd9, 32'h0);
      bus.out_ready = 1'b1;
      step();
      idle_in();
      bus.out_ready = 1'b0;
      chk("pp_dest",  bus.dest_out, 4'd6);
      chk("pp_val",   bus.WB_value, 32'd9);
      chk("pp_count1", bus.in_ready, 1'b1);
      bus.out_ready = 1'b1;
      step();
      chk("pp_empty", bus.out_valid, 1'b0);

      // bubble: accepted, never stored
      bus.out_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 4'd7, 32'h77, 32'h0);
      chk("bub_ready", bus.in_ready, 1'b1);
      step();
      step();
      idle_in();
      chk("bub_no_entry", bus.out_valid, 1'b0);

      // hazard query and flush
      drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h55, 32'h0);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd8, 32'h88, 32'h0);
      step();
      idle_in();
      bus.src1 = 4'd8;
      bus.src2 = 4'd0;
      #1;
      chk("hz_hit", bus.hazard, 1'b1);
      bus.src1 = 4'd9;
      bus.src2 = 4'd9;
      #1;
      chk("hz_miss", bus.hazard, 1'b0);
      bus.flush = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 4'd12, 32'hC, 32'h0);
      step();
      bus.flush = 1'b0;
      idle_in();
      bus.src1 = 4'd5;
      bus.src2 = 4'd8;
      #1;
      chk("fl_empty",  bus.out_valid, 1'b0);
      chk("fl_hazard", bus.hazard,    1'b0);
      step();
      chk("fl_no_push", bus.out_valid, 1'b0);

      // asynchronous reset with a full buffer
      drive(1'b1, 1'b1, 1'b0, 4'd13, 32'hAAAA, 32'h0);
      step();
      drive(1'b1, 1'b1, 1'b0, 4'd14, 32'hBBBB, 32'h0);
      step();
      idle_in();
      bus.src1 = 4'd13;
      chk("ar_full", bus.in_ready, 1'b0);
      #1 rst = 1'b0;
      #1;
      chk("ar_out_valid", bus.out_valid, 1'b0);
      chk("ar_wb_value",  bus.WB_value,  32'd0);
      chk("ar_in_ready",  bus.in_ready,  1'b1);
      chk("ar_hazard",    bus.hazard,    1'b0);
      step();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 4'd11, 32'h9, 32'h1234);
      step();
      idle_in();
      chk("ar_resume_dest", bus.dest_out, 4'd11);
      chk("ar_resume_val",  bus.WB_value, 32'h1234);
      step();

      // mixed traffic, checked by the model every cycle
      for (int i = 0; i < 60; i++) begin
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               DEST_W'($urandom_range(0, 15)), $urandom, $urandom);
         bus.out_ready = $urandom_range(0, 2) != 0;
         bus.flush     = $urandom_range(0, 15) == 0;
         bus.src1      = DEST_W'($urandom_range(0, 15));
         bus.src2      = DEST_W'($urandom_range(0, 15));
         step();
      end
      idle_in();
      bus.flush = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_wb_buffer.md
MEM_WB_BUFFER -- requirements
Module: mem_wb_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the write-back value and ALU/memory data.
REQ-002 The block SHALL have parameter DEST_W, default 4, meaning the width of the register-file destination index.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock (only clock).
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 The block SHALL have port in_valid  input  1  MEM stage presents a result.
REQ-007 The block SHALL have port in_ready  output  1  buffer can accept a result this cycle.
REQ-008 The block SHALL have port WB_en_in  input  1  result writes the register file.
REQ-009 The block SHALL have port MEM_r_en_in  input  1  result is a load.
REQ-010 The block SHALL have port dest_in  input  DEST_W  destination register.
REQ-011 The block SHALL have port alu_res_in  input  DATA_W  ALU result from MEM stage.
REQ-012 The block SHALL have port data_mem_in  input  DATA_W  data-memory read data from MEM stage.
REQ-013 The block SHALL have port out_valid  output  1  head entry present.
REQ-014 The block SHALL have port out_ready  input  1  register-file write port accepts the head.
REQ-015 The block SHALL have port WB_en_out  output  1  register-file write enable.
REQ-016 The block SHALL have port dest_out  output  DEST_W  register-file write index.
REQ-017 The block SHALL have port WB_value  output  DATA_W  register-file write data.
REQ-018 The block SHALL have port src1, src2  input  DEST_W each  hazard-query source registers.
REQ-019 The block SHALL have port hazard  output  1  a buffered entry writes src1 or src2.

Function
REQ-020 The block SHALL be a 2-entry FIFO; entry = {dest, value}, value = MEM_r_en_in ? data_mem_in : alu_res_in, selected at capture.
REQ-021 in_ready SHALL be 1 iff stored count < 2, derived from registered count only (no combinational path from out_ready).
REQ-022 A push SHALL occur on a rising edge with in_valid & in_ready & WB_en_in & ~flush; in_valid & in_ready & ~WB_en_in SHALL be accepted and discarded (bubble, no entry).
REQ-023 A pop SHALL occur on a rising edge with out_valid & out_ready & ~flush.
REQ-024 out_valid SHALL be 1 iff count != 0; WB_en_out SHALL equal out_valid; dest_out/WB_value SHALL show the head entry, and SHALL be 0 when empty.
REQ-025 Latency SHALL be one cycle: a result pushed at edge N SHALL appear on outputs after edge N when the buffer was empty.
REQ-026 Simultaneous push and pop with count=1 SHALL leave count=1 with the new entry at head; with count=0 no pop occurs.
REQ-027 With count=2, in_ready=0; a pop SHALL raise in_ready in the following cycle.
REQ-028 Order SHALL be strictly FIFO; pointers wrap modulo 2.
REQ-029 flush SHALL set count to 0 at the edge, overriding any push or pop in that cycle.
REQ-030 hazard SHALL be combinational: 1 iff any valid entry has dest equal to src1 or src2.

Reset
REQ-031 While rst=0, count SHALL be 0, out_valid=0, WB_en_out=0, dest_out=0, WB_value=0, hazard=0, in_ready=1, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately; operation resumes on the first edge after rst returns to 1.

Verification
REQ-033 Bench SHALL cover: single load, dest=3, alu_res=0x100, data_mem=0xDEAD, out_ready=1 -> next cycle WB_en_out=1, dest_out=3, WB_value=0xDEAD; then out_valid=0.
REQ-034 Bench SHALL cover: out_ready=0, push ALU ops dest=1 val=5, dest=2 val=7, third pending -> in_ready=0; release out_ready -> outputs 1/5 then 2/7, third accepted after first pop.
REQ-035 Bench SHALL cover: count=1 head dest=4, push dest=6 val=9 with out_ready=1 same edge -> count=1, head dest=6 val=9.
REQ-036 Bench SHALL cover: in_valid=1, WB_en_in=0 -> in_ready=1, no entry, out_valid stays 0.
REQ-037 Bench SHALL cover: two entries dest=5, dest=8; src1=8 -> hazard=1; src1=src2=9 -> hazard=0; flush with in_valid=1 -> count=0, hazard=0, no push.
REQ-038 Bench SHALL cover: rst=0 asynchronously between edges with count=2 -> out_valid=0, WB_value=0, in_ready=1 before next edge.
